instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the fetch address loaded on reset.
REQ-002 The block SHALL have parameter IMEM_BYTES, default 1024, meaning the instruction memory size in bytes.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port imem_addr  output  64  fetch address driven to instruction memory.
REQ-006 The block SHALL have port imem_instr  input  32  instruction word returned combinationally by memory for imem_addr.
REQ-007 The block SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 The block SHALL have port redirect_pc  input  64  redirect target address.
REQ-009 The block SHALL have port out_valid  output  1  buffer head holds a valid instruction.
REQ-010 The block SHALL have port out_ready  input  1  decode stage accepts the head entry.
REQ-011 The block SHALL have port out_instr  output  32  head instruction word.
REQ-012 The block SHALL have port out_pc  output  64  address of the head instruction.
REQ-013 The block SHALL have port fault  output  1  sticky fetch fault (misaligned or out-of-range address).

Function
REQ-014 The block SHALL hold a fetch_pc register and drive imem_addr = fetch_pc combinationally.
REQ-015 The block SHALL contain a 2-entry FIFO of {pc[63:0], instr[31:0]} with count 0..2, read pointer and write pointer each wrapping 1->0.
REQ-016 Enqueue SHALL occur in a cycle when fault=0, redirect_valid=0, the fetch address is legal, and (count<2 or a dequeue occurs that cycle); the entry SHALL be {fetch_pc, imem_instr} and fetch_pc SHALL advance by 4 (64-bit add, wrap modulo 2^64).
REQ-017 Dequeue SHALL occur in a cycle when out_valid=1 and out_ready=1; the head SHALL advance.
REQ-018 Full with simultaneous dequeue and enqueue SHALL leave count=2; empty with out_ready=1 SHALL change nothing.
REQ-019 out_valid SHALL equal (count!=0); out_instr/out_pc SHALL show the head entry, driven 0 when empty.
REQ-020 While out_valid=1 and out_ready=0, out_instr and out_pc SHALL stay stable.
REQ-021 Latency: an instruction at fetch_pc=P in cycle N SHALL be visible at out_pc=P no earlier than cycle N+1.
REQ-022 A fetch address SHALL be legal iff fetch_pc[1:0]==0 and fetch_pc+3 <= IMEM_BYTES-1.
REQ-023 An illegal fetch address with redirect_valid=0 SHALL set fault=1 and suppress enqueue; fault SHALL remain 1 and fetch_pc SHALL hold until redirect or reset; buffered entries SHALL still drain.
REQ-024 redirect_valid=1 SHALL take priority over all other events: the FIFO SHALL be flushed (count=0, pointers 0), any same-cycle dequeue and enqueue discarded, fault cleared, fetch_pc loaded with redirect_pc.
REQ-025 The cycle after a redirect SHALL show out_valid=0; the target instruction SHALL appear the following cycle if legal.

Reset
REQ-026 Asserting reset SHALL immediately, without a clock edge, set fetch_pc=RESET_PC, count=0, pointers=0, fault=0, out_valid=0, out_instr=0, out_pc=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries and any pending redirect.
REQ-028 The first enqueue after reset deassertion SHALL occur at the first rising edge with reset low.

Verification
REQ-029 Reset release, out_ready=1, memory word 0=0x007404B3, word 4=0x00A00293 -> out_pc=0/out_instr=0x007404B3, then out_pc=4/out_instr=0x00A00293 on consecutive cycles.
REQ-030 out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 8, out_pc stays 0; then out_ready=1 -> out_pc sequence 0,4,8 with no gaps or duplicates.
REQ-031 Buffer full, redirect_valid=1 with redirect_pc=0x10 and out_ready=1 in the same cycle -> next cycle out_valid=0, imem_addr=0x10; the following cycle out_pc=0x10 with no stale entry delivered.
REQ-032 redirect_pc=0x6 (misaligned) -> fault=1, no enqueue, out_valid=0 once drained; subsequent redirect to 0x0 -> fault=0, out_pc=0 delivered.
REQ-033 Sequential fetch reaching 0x3FC with IMEM_BYTES=1024 -> 0x3FC delivered, fetch_pc=0x400 raises fault=1, and no further entries are delivered.
REQ-034 reset asserted between clock edges while count=2 -> out_valid and out_pc drop to 0 before the next edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Sequential instruction fetcher feeding a 2-entry {pc, instr} buffer that
//   the decode stage drains with a valid/ready handshake.
//   - fetch_pc_reg drives imem_addr; memory returns imem_instr combinationally.
//   - A fetch is accepted only for word-aligned addresses that lie fully inside
//     the instruction memory. Otherwise a sticky fault freezes fetching until
//     the next redirect. Entries already in the buffer still drain.
//   - A redirect flushes the buffer, clears the fault and reloads fetch_pc.
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   imem_addr/imem_instr  : instruction memory address / returned word
//   redirect_valid/_pc    : branch/jump redirect request and target
//   out_valid/ready/instr/pc : buffer head handshake to decode
//   fault                 : sticky misaligned / out-of-range fetch indication
module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          IMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        fault
);

   // Last valid byte address, widened so fetch_pc+3 cannot wrap in the compare.
   localparam logic [64:0] LAST_BYTE = 65'(IMEM_BYTES) - 65'd1;

   logic [63:0] fetch_pc_reg, fetch_pc_next;
   logic [1:0]  count_reg, count_next;
   logic        rd_ptr_reg, rd_ptr_next;
   logic        wr_ptr_reg, wr_ptr_next;
   logic        fault_reg, fault_next;

   logic [63:0] entry_pc    [2];
   logic [31:0] entry_instr [2];

   logic legal;
   logic deq;
   logic enq;

   assign legal = (fetch_pc_reg[1:0] == 2'b00) &&
                  (({1'b0, fetch_pc_reg} + 65'd3) <= LAST_BYTE);

   // A redirect discards anything the handshake would otherwise do this cycle.
   assign deq = out_valid && out_ready && !redirect_valid;
   assign enq = !fault_reg && !redirect_valid && legal &&
                ((count_reg != 2'd2) || deq);

   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      count_next    = count_reg;
      rd_ptr_next   = rd_ptr_reg;
      wr_ptr_next   = wr_ptr_reg;
      fault_next    = fault_reg;
      if (redirect_valid) begin
         fetch_pc_next = redirect_pc;
         count_next    = 2'd0;
         rd_ptr_next   = 1'b0;
         wr_ptr_next   = 1'b0;
         fault_next    = 1'b0;
      end else begin
         if (deq) begin
            rd_ptr_next = ~rd_ptr_reg;
         end
         if (enq) begin
            wr_ptr_next   = ~wr_ptr_reg;
            fetch_pc_next = fetch_pc_reg + 64'd4;
         end
         // Fault latches once; fetch_pc then holds because enq stays low.
         if (!fault_reg && !legal) begin
            fault_next = 1'b1;
         end
         case ({enq, deq})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_reg <= RESET_PC;
         count_reg    <= 2'd0;
         rd_ptr_reg   <= 1'b0;
         wr_ptr_reg   <= 1'b0;
         fault_reg    <= 1'b0;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         count_reg    <= count_next;
         rd_ptr_reg   <= rd_ptr_next;
         wr_ptr_reg   <= wr_ptr_next;
         fault_reg    <= fault_next;
      end
   end

   // Entry payloads need no reset: they are only visible while count_reg != 0.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (enq && (wr_ptr_reg == 1'(gi))) begin
               entry_pc[gi]    <= fetch_pc_reg;
               entry_instr[gi] <= imem_instr;
            end
         end
      end
   endgenerate

   assign imem_addr = fetch_pc_reg;
   assign fault     = fault_reg;
   assign out_valid = (count_reg != 2'd0);
   assign out_pc    = out_valid ? entry_pc[rd_ptr_reg]    : 64'd0;
   assign out_instr = out_valid ? entry_instr[rd_ptr_reg] : 32'd0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios followed by random
// redirect / back-pressure / reset traffic, all checked against a queue-based
// reference model of the fetch buffer.
module tb_instruction_fetch_unit;

   localparam int IMEM_BYTES = 1024;

   logic        clk;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        fault;

   logic [31:0] mem [256];

   instruction_fetch_unit #(
      .RESET_PC   (64'h0),
      .IMEM_BYTES (IMEM_BYTES)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fault          (fault)
   );

   assign imem_instr = (imem_addr < 64'(IMEM_BYTES)) ? mem[imem_addr[9:2]] : 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: buffer as a queue of {pc, instr}.
   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      m_q [$];
   logic [63:0] m_pc;
   logic        m_fault;

   function automatic logic m_legal(input logic [63:0] a);
      return (a % 4 == 0) && (a <= 64'(IMEM_BYTES - 4));
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pc    = 64'h0;
      m_fault = 1'b0;
   endtask

   task automatic compare_all();
      check_eq("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      check_eq("out_pc",    out_pc,    (m_q.size() != 0) ? m_q[0].pc : 64'h0);
      check_eq("out_instr", 64'(out_instr), (m_q.size() != 0) ? 64'(m_q[0].instr) : 64'h0);
      check_eq("imem_addr", imem_addr, m_pc);
      check_eq("fault",     64'(fault), 64'(m_fault));
   endtask

   // Called at a falling edge: drive inputs, compare, advance model, wait one cycle.
   task automatic step(input logic rv, input logic [63:0] rpc, input logic rdy);
      int     n;
      logic   popped;
      entry_t e;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
      compare_all();
      if (rv) begin
         m_q.delete();
         m_fault = 1'b0;
         m_pc    = rpc;
      end else begin
         n      = m_q.size();
         popped = (n > 0) && rdy;
         if (popped) void'(m_q.pop_front());
         if (!m_fault && m_legal(m_pc) && (n < 2 || popped)) begin
            e.pc    = m_pc;
            e.instr = mem[m_pc[9:2]];
            m_q.push_back(e);
            m_pc = m_pc + 64'd4;
         end else if (!m_fault && !m_legal(m_pc)) begin
            m_fault = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   // Asserts reset between edges, checks the immediate effect, releases at next falling edge.
   task automatic apply_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      check_eq({tag, "_valid"}, 64'(out_valid), 64'h0);
      check_eq({tag, "_pc"},    out_pc,    64'h0);
      check_eq({tag, "_instr"}, 64'(out_instr), 64'h0);
      check_eq({tag, "_addr"},  imem_addr, 64'h0);
      check_eq({tag, "_fault"}, 64'(fault), 64'h0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   function automatic logic [63:0] pick_target();
      case ($urandom_range(0, 5))
         0:       return 64'({$urandom_range(0, 255), 2'b00});
         1:       return 64'($urandom_range(0, 1023));
         2:       return 64'h3F0 + 64'({$urandom_range(0, 3), 2'b00});
         3:       return 64'h400 + 64'($urandom_range(0, 64));
         4:       return 64'hFFFF_FFFF_FFFF_FFFC;
         default: return 64'({$urandom_range(200, 255), 2'b00});
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h007404B3;
      mem[1] = 32'h00A00293;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      out_ready      = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Consecutive delivery of words 0 and 4.
      step(1'b0, 64'h0, 1'b1);
      check_eq("seq_pc0",    out_pc, 64'h0);
      check_eq("seq_instr0", 64'(out_instr), 64'h007404B3);
      step(1'b0, 64'h0, 1'b1);
      check_eq("seq_pc4",    out_pc, 64'h4);
      check_eq("seq_instr4", 64'(out_instr), 64'h00A00293);

      // Back-pressure saturates the buffer.
      apply_reset("rst1");
      repeat (5) step(1'b0, 64'h0, 1'b0);
      check_eq("bp_addr",  imem_addr, 64'h8);
      check_eq("bp_pc",    out_pc, 64'h0);
      check_eq("bp_valid", 64'(out_valid), 64'h1);
      step(1'b0, 64'h0, 1'b1);
      check_eq("drain_pc4", out_pc, 64'h4);
      step(1'b0, 64'h0, 1'b1);
      check_eq("drain_pc8", out_pc, 64'h8);

      // Redirect while full and dequeuing.
      step(1'b1, 64'h10, 1'b1);
      check_eq("redir_valid", 64'(out_valid), 64'h0);
      check_eq("redir_addr",  imem_addr, 64'h10);
      step(1'b0, 64'h0, 1'b0);
      check_eq("redir_pc", out_pc, 64'h10);

      // Misaligned redirect faults, redirect to 0 recovers.
      step(1'b1, 64'h6, 1'b1);
      step(1'b0, 64'h0, 1'b1);
      check_eq("mis_fault", 64'(fault), 64'h1);
      check_eq("mis_valid", 64'(out_valid), 64'h0);
      step(1'b0, 64'h0, 1'b1);
      check_eq("mis_hold", imem_addr, 64'h6);
      step(1'b1, 64'h0, 1'b1);
      check_eq("rec_fault", 64'(fault), 64'h0);
      step(1'b0, 64'h0, 1'b1);
      check_eq("rec_pc",    out_pc, 64'h0);
      check_eq("rec_valid", 64'(out_valid), 64'h1);

      // Running off the end of memory.
      step(1'b1, 64'h3F8, 1'b1);
      step(1'b0, 64'h0, 1'b1);
      check_eq("end_pc3f8", out_pc, 64'h3F8);
      step(1'b0, 64'h0, 1'b1);
      check_eq("end_pc3fc", out_pc, 64'h3FC);
      step(1'b0, 64'h0, 1'b1);
      check_eq("end_fault", 64'(fault), 64'h1);
      check_eq("end_valid", 64'(out_valid), 64'h0);
      check_eq("end_addr",  imem_addr, 64'h400);
      step(1'b0, 64'h0, 1'b1);
      check_eq("end_quiet", 64'(out_valid), 64'h0);

      // Mid-operation reset with a full buffer.
      step(1'b1, 64'h20, 1'b0);
      step(1'b0, 64'h0, 1'b0);
      step(1'b0, 64'h0, 1'b0);
      check_eq("full_valid", 64'(out_valid), 64'h1);
      apply_reset("rst2");
      step(1'b0, 64'h0, 1'b1);
      check_eq("restart_pc", out_pc, 64'h0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            apply_reset("rst_rand");
         end else begin
            step(($urandom_range(0, 19) == 0), pick_target(), ($urandom_range(0, 3) != 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
